// File: rtl/imm_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_if
// Description : Bundle of the fetch-side and execute-side signals of the
//               AArch64 immediate generator: input handshake, output queue
//               head, queue flush and the unrecognised-encoding counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_kind;
    logic [5:0]       out_shift;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      unrec_cnt;

    // Fetch/consumer side: offers instructions and drains the queue
    modport master (
        output flush, in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_kind, out_shift, out_tag,
               unrec_cnt
    );

    // Immediate generator side
    modport slave (
        input  flush, in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_kind, out_shift, out_tag,
               unrec_cnt
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : AArch64 immediate generator. Classifies each accepted 32-bit
//               instruction, expands its immediate (shifted, sign- or
//               zero-extended) and queues {imm, kind, shift, tag} in a
//               DEPTH-entry circular buffer. Counts unrecognised encodings
//               (saturating at 0xFFFF).
//               Optional macro IMM_GEN_BRANCH_EN enables decoding of B/BL
//               (kind 6) and CBZ/CBNZ/B.cond (kind 7); without it those
//               encodings decode as NONE.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  wire         clk,
    input  wire         rst,
    imm_gen_if.slave    bus
);

    localparam int c_PTR_W = $clog2(DEPTH);

    localparam logic [2:0] c_KIND_NONE   = 3'd0;
    localparam logic [2:0] c_KIND_MOVZ   = 3'd1;
    localparam logic [2:0] c_KIND_MOVN   = 3'd2;
    localparam logic [2:0] c_KIND_MOVK   = 3'd3;
    localparam logic [2:0] c_KIND_ADDSUB = 3'd4;
    localparam logic [2:0] c_KIND_LDST   = 3'd5;
`ifdef IMM_GEN_BRANCH_EN
    localparam logic [2:0] c_KIND_BR26   = 3'd6;
    localparam logic [2:0] c_KIND_BR19   = 3'd7;
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [15:0] w_imm16;
    logic [11:0] w_imm12;
    logic [5:0]  w_hw_shift;
    logic [63:0] w_wide;
    logic [63:0] w_imm64;
    logic [2:0]  w_kind;
    logic [5:0]  w_shift;

    assign w_imm16    = bus.in_inst[20:5];
    assign w_imm12    = bus.in_inst[21:10];
    assign w_hw_shift = {bus.in_inst[22:21], 4'b0000};
    assign w_wide     = {48'd0, w_imm16} << w_hw_shift;

    // Classify the instruction word and build the 64-bit immediate
    always_comb begin
        w_kind  = c_KIND_NONE;
        w_imm64 = 64'd0;
        w_shift = 6'd0;
        if (bus.in_inst[31:23] == 9'b110100101) begin
            w_kind  = c_KIND_MOVZ;
            w_imm64 = w_wide;
        end else if (bus.in_inst[31:23] == 9'b100100101) begin
            w_kind  = c_KIND_MOVN;
            w_imm64 = ~w_wide;
        end else if (bus.in_inst[31:23] == 9'b111100101) begin
            // MOVK carries the insertion position so execute can merge
            w_kind  = c_KIND_MOVK;
            w_imm64 = w_wide;
            w_shift = w_hw_shift;
        end else if (bus.in_inst[31] && (bus.in_inst[28:23] == 6'b100010)) begin
            w_kind  = c_KIND_ADDSUB;
            w_imm64 = bus.in_inst[22] ? {40'd0, w_imm12, 12'd0}
                                      : {52'd0, w_imm12};
        end else if (bus.in_inst[31:23] == 9'b111110010) begin
            // Bit 22 selects LDR vs STR; both scale imm12 by 8
            w_kind  = c_KIND_LDST;
            w_imm64 = {49'd0, w_imm12, 3'b000};
`ifdef IMM_GEN_BRANCH_EN
        end else if (bus.in_inst[30:26] == 5'b00101) begin
            w_kind  = c_KIND_BR26;
            w_imm64 = {{36{bus.in_inst[25]}}, bus.in_inst[25:0], 2'b00};
        end else if ((bus.in_inst[31:25] == 7'b1011010) ||
                     ((bus.in_inst[31:24] == 8'b01010100) && !bus.in_inst[4])) begin
            w_kind  = c_KIND_BR19;
            w_imm64 = {{43{bus.in_inst[23]}}, bus.in_inst[23:5], 2'b00};
`endif
        end
    end

    // Register fields not consumed in every configuration (Rd, upper imm bits)
    logic w_unused;
    assign w_unused = ^{bus.in_inst[4:0], w_imm64};

    // ------------------------------------------------------------------
    // Output queue
    // ------------------------------------------------------------------
    logic [XLEN-1:0]    r_imm_q   [DEPTH];
    logic [2:0]         r_kind_q  [DEPTH];
    logic [5:0]         r_shift_q [DEPTH];
    logic [TAG_W-1:0]   r_tag_q   [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [15:0]        r_unrec_cnt;

    logic w_full;
    logic w_accept;
    logic w_pop;
    logic w_push;

    // DEPTH is a power of two, so the count MSB alone marks "full"
    assign w_full   = r_count[c_PTR_W];
    assign w_accept = bus.in_valid & ~w_full;
    assign w_pop    = (r_count != '0) & bus.out_ready;
    assign w_push   = w_accept & ~bus.flush;

    // Pointer and occupancy tracking; flush empties the queue in one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; only entry 0 is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imm_q[0]   <= '0;
            r_kind_q[0]  <= '0;
            r_shift_q[0] <= '0;
            r_tag_q[0]   <= '0;
        end else if (w_push) begin
            r_imm_q[r_wr_ptr]   <= w_imm64[XLEN-1:0];
            r_kind_q[r_wr_ptr]  <= w_kind;
            r_shift_q[r_wr_ptr] <= w_shift;
            r_tag_q[r_wr_ptr]   <= bus.in_tag;
        end
    end

    // Saturating count of unrecognised words, including ones dropped by flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_unrec_cnt <= 16'd0;
        end else if (w_accept && (w_kind == c_KIND_NONE) && (r_unrec_cnt != 16'hFFFF)) begin
            r_unrec_cnt <= r_unrec_cnt + 16'd1;
        end
    end

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_imm   = r_imm_q[r_rd_ptr];
    assign bus.out_kind  = r_kind_q[r_rd_ptr];
    assign bus.out_shift = r_shift_q[r_rd_ptr];
    assign bus.out_tag   = r_tag_q[r_rd_ptr];
    assign bus.unrec_cnt = r_unrec_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen
// Description : Directed, table-driven bench for imm_gen (XLEN=64, DEPTH=4,
//               TAG_W=8), plus sequences for queue full/drain, flush,
//               counter saturation and mid-stream reset. Branch expectations
//               follow IMM_GEN_BRANCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    imm_gen_if #(.XLEN(64), .TAG_W(8)) bus ();

    imm_gen #(.XLEN(64), .DEPTH(4), .TAG_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] inst;
        logic [7:0]  tag;
        logic [63:0] imm;
        logic [2:0]  kind;
        logic [5:0]  shift;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_err    = 0;
    int exp_unrec = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{32'hD2C24680, 8'h5A, 64'h0000123400000000, 3'd1, 6'd0};
        vecs[1]  = '{32'hF2B7DDE1, 8'h01, 64'h00000000BEEF0000, 3'd3, 6'd16};
        vecs[2]  = '{32'hD1400442, 8'h02, 64'h0000000000001000, 3'd4, 6'd0};
        vecs[3]  = '{32'h92800000, 8'h03, 64'hFFFFFFFFFFFFFFFF, 3'd2, 6'd0};
        vecs[4]  = '{32'h92A01FE0, 8'h04, 64'hFFFFFFFFFF00FFFF, 3'd2, 6'd0};
        vecs[5]  = '{32'hF9448C00, 8'h05, 64'h0000000000000918, 3'd5, 6'd0};
        vecs[6]  = '{32'hF93FFC00, 8'h06, 64'h0000000000007FF8, 3'd5, 6'd0};
        vecs[7]  = '{32'h912AF000, 8'h07, 64'h0000000000000ABC, 3'd4, 6'd0};
        vecs[8]  = '{32'h00000000, 8'h08, 64'h0,                3'd0, 6'd0};
        vecs[9]  = '{32'h54000010, 8'h09, 64'h0,                3'd0, 6'd0};
`ifdef IMM_GEN_BRANCH_EN
        vecs[10] = '{32'h17FFFFFF, 8'h0A, 64'hFFFFFFFFFFFFFFFC, 3'd6, 6'd0};
        vecs[11] = '{32'h94000010, 8'h0B, 64'h0000000000000040, 3'd6, 6'd0};
        vecs[12] = '{32'hB40000A0, 8'h0C, 64'h0000000000000014, 3'd7, 6'd0};
        vecs[13] = '{32'h54FFFFE0, 8'h0D, 64'hFFFFFFFFFFFFFFFC, 3'd7, 6'd0};
`else
        vecs[10] = '{32'h17FFFFFF, 8'h0A, 64'h0, 3'd0, 6'd0};
        vecs[11] = '{32'h94000010, 8'h0B, 64'h0, 3'd0, 6'd0};
        vecs[12] = '{32'hB40000A0, 8'h0C, 64'h0, 3'd0, 6'd0};
        vecs[13] = '{32'h54FFFFE0, 8'h0D, 64'h0, 3'd0, 6'd0};
`endif

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'd0;
        bus.in_tag    = 8'd0;
        bus.out_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready",  64'(bus.in_ready), 64'd1);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset unrec_cnt", 64'(bus.unrec_cnt), 64'd0);
        chk("reset out_imm",   bus.out_imm, 64'd0);
        chk("reset out_kind",  64'(bus.out_kind), 64'd0);
        chk("reset out_shift", 64'(bus.out_shift), 64'd0);
        chk("reset out_tag",   64'(bus.out_tag), 64'd0);

        // ---------------- table of single instructions ----------------
        bus.out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_inst  = vecs[i].inst;
            bus.in_tag   = vecs[i].tag;
            if (vecs[i].kind == 3'd0) exp_unrec++;
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("vec%0d out_imm", i),   bus.out_imm, vecs[i].imm);
            chk($sformatf("vec%0d out_kind", i),  64'(bus.out_kind), 64'(vecs[i].kind));
            chk($sformatf("vec%0d out_shift", i), 64'(bus.out_shift), 64'(vecs[i].shift));
            chk($sformatf("vec%0d out_tag", i),   64'(bus.out_tag), 64'(vecs[i].tag));
            chk($sformatf("vec%0d unrec_cnt", i), 64'(bus.unrec_cnt), 64'(exp_unrec));
        end
        @(negedge clk);
        chk("table drained out_valid", 64'(bus.out_valid), 64'd0);

        // ---------------- fill to DEPTH, then drain in order ----------------
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = 32'hD2800000 | (32'(i) << 5);
            bus.in_tag   = 8'(i);
            chk($sformatf("fill%0d in_ready", i), 64'(bus.in_ready), (i < 4) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("full in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d out_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("drain%0d out_tag", i),   64'(bus.out_tag), 64'(i));
            chk($sformatf("drain%0d out_imm", i),   bus.out_imm, 64'(i));
            @(negedge clk);
            if (i == 0) chk("in_ready after first pop", 64'(bus.in_ready), 64'd1);
        end
        chk("drained out_valid", 64'(bus.out_valid), 64'd0);

        // ---------------- flush with a concurrent unrecognised accept ----------------
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = 32'hD2800020;
            bus.in_tag   = 8'h10 + 8'(i);
            @(negedge clk);
        end
        chk("pre-flush out_valid", 64'(bus.out_valid), 64'd1);
        bus.in_inst = 32'h00000000;
        bus.in_tag  = 8'hEE;
        bus.flush   = 1'b1;
        exp_unrec++;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush in_ready",  64'(bus.in_ready), 64'd1);
        chk("flush unrec_cnt", 64'(bus.unrec_cnt), 64'(exp_unrec));
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'hF2B7DDE1;
        bus.in_tag   = 8'h77;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("post-flush out_tag",  64'(bus.out_tag), 64'h77);
        chk("post-flush out_kind", 64'(bus.out_kind), 64'd3);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post-flush drained", 64'(bus.out_valid), 64'd0);

        // ---------------- unrec_cnt saturation ----------------
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00000000;
        for (int i = 0; i < 32'h10000; i++) begin
            bus.in_tag = 8'(i);
            @(negedge clk);
        end
        chk("saturated unrec_cnt", 64'(bus.unrec_cnt), 64'hFFFF);
        @(negedge clk);
        chk("held unrec_cnt", 64'(bus.unrec_cnt), 64'hFFFF);

        // ---------------- mid-stream reset ----------------
        bus.out_ready = 1'b0;
        bus.in_inst   = 32'hD2C24680;
        bus.in_tag    = 8'h33;
        repeat (2) @(negedge clk);
        chk("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst unrec_cnt", 64'(bus.unrec_cnt), 64'd0);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst in_ready",  64'(bus.in_ready), 64'd1);
        chk("rst out_tag",   64'(bus.out_tag), 64'd0);
        chk("rst out_imm",   bus.out_imm, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen.md
# imm_gen

Parametrised AArch64 immediate generator with a valid/ready input, a registered decode stage and a DEPTH-entry output queue. It classifies each 32-bit instruction and produces the fully expanded, shifted and sign- or zero-extended immediate, plus a kind code and a caller tag. It sits between fetch and the execute operand mux and replaces single-cycle combinational immediate padding. It also counts unrecognised encodings.

## Interface
- `XLEN`, 64: immediate width; legal values are 32 and 64. Results are computed at 64 bits and truncated to XLEN.
- `DEPTH`, 4: output queue entries; power of 2, ≥2.
- `TAG_W`, 8: width of the tag carried alongside each instruction.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `flush`  in  1  synchronous queue clear.
- `in_valid`  in  1  an instruction is offered.
- `in_ready`  out  1  the block can accept.
- `in_inst`  in  32  instruction word.
- `in_tag`  in  TAG_W  caller tag, passed through unchanged.
- `out_valid`  out  1  queue head is valid.
- `out_ready`  in  1  consumer takes the head.
- `out_imm`  out  XLEN  expanded immediate.
- `out_kind`  out  3  kind code (see Operation).
- `out_shift`  out  6  MOVK insertion position (16·hw); 0 for all other kinds.
- `out_tag`  out  TAG_W  tag of the head entry.
- `unrec_cnt`  out  16  count of unrecognised instructions; saturates at 0xFFFF.

## Operation
- Decode is combinational on `in_inst`. The result is written into the queue on accept (`in_valid & in_ready`).
- Kinds, all matched on 64-bit (sf=1) forms:
  - 0 NONE: no match; imm 0; `unrec_cnt` increments.
  - 1 MOVZ, `[31:23]=110100101`: imm16 `[20:5]` << 16·hw, where hw is `[22:21]`.
  - 2 MOVN, `[31:23]=100100101`: ~(imm16 << 16·hw).
  - 3 MOVK, `[31:23]=111100101`: imm16 << 16·hw; `out_shift` = 16·hw.
  - 4 ADDSUB: `[31]=1` and `[28:23]=100010`. Covers ADD/ADDS/SUB/SUBS. imm12 `[21:10]`, zero-extended, << 12 when sh `[22]` is 1.
  - 5 LDST: `[31:22]=1111100101` (LDR) or `1111100100` (STR). imm12 `[21:10]` << 3, zero-extended.
  - 6 BR26: `[30:26]=00101` (B and BL). sext(imm26 `[25:0]` << 2).
  - 7 BR19: CBZ/CBNZ with `[31:25]=1011010`, or B.cond with `[31:24]=01010100` and `[4]=0`. sext(imm19 `[23:5]` << 2).
- Queue: circular, with read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- `in_ready` = (count < DEPTH). Full blocks input even when a pop happens in the same cycle; there is no pass-through.
- `out_valid` = (count != 0). Head fields come straight from the register array.
- Push and pop in the same cycle leave count unchanged.
- `flush` zeroes pointers and count in one cycle. An accept in the same cycle is discarded. `unrec_cnt` is not affected by `flush`, but still counts the discarded instruction if it was unrecognised.
- Reset zeroes pointers, count and `unrec_cnt`. Queue contents are don't-care after reset.

## Timing
- Accept at edge N with the queue empty: `out_valid`=1 after edge N (1-cycle latency).
- Throughput is one instruction per cycle while not full and the consumer is ready.
- Reset values: `in_ready`=1, `out_valid`=0, `unrec_cnt`=0. `out_imm`, `out_kind`, `out_shift` and `out_tag` read as 0 after reset because the entry 0 register is cleared.
- `unrec_cnt` updates on the same edge as the accept.
- Reset asserted mid-stream drops all entries on that edge; `rst` has priority over `flush`.

## Configuration
- `IMM_GEN_BRANCH_EN` defined: kinds 6 and 7 are decoded as above.
- Not defined: branch encodings decode as NONE (imm 0, `unrec_cnt` increments), and the branch sign-extension logic is absent.

## Test plan
- MOVZ X0,#0x1234,LSL#32 (0xD2C24680), tag 0x5A, `out_ready`=1 -> one cycle later: imm 0x0000123400000000, kind 1, shift 0, tag 0x5A.
- MOVK X1,#0xBEEF,LSL#16 (0xF2B7DDE1); SUB X2,X2,#1,LSL#12 (0xD1400442) -> imm 0xBEEF0000, kind 3, shift 16; then imm 0x1000, kind 4.
- With the macro defined, B with imm26=0x3FFFFFF (0x17FFFFFF) -> imm 0xFFFFFFFFFFFFFFFC, kind 6. Without the macro -> kind 0, imm 0, `unrec_cnt`=1.
- DEPTH=4, `out_ready`=0, push 5 back-to-back -> `in_ready` drops after the 4th accept. Raise `out_ready` -> entries drain in order with tags 0..3, and `in_ready` reasserts the cycle after the first pop.
- Queue holds 3 entries; assert `flush` together with an accept of 0x00000000 -> next cycle `out_valid`=0, count 0, `unrec_cnt` incremented by 1.
- Feed 0x10000 unrecognised words -> `unrec_cnt` holds at 0xFFFF. Assert `rst` -> `unrec_cnt`=0, `out_valid`=0, `in_ready`=1.
